// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS controller: opcode/funct
// constants, ALU control and forward-select encodings, the per-stage
// control payload and the ALU control decoder.
package mips_pkg;

  localparam int unsigned OP_W   = 6;
  localparam int unsigned ALUC_W = 3;
  localparam int unsigned FWD_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;

  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUC_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUC_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUC_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUC_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUC_W-1:0] ALU_SLT = 3'b111;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef struct packed {
    logic              regwrite;
    logic              memtoreg;
    logic              memwrite;
    logic              alusrc;
    logic              regdst;
    logic [ALUC_W-1:0] alucontrol;
  } ctrl_t;

  // Map aluop (and funct for R-type) onto the ALU control encoding.
  function automatic logic [ALUC_W-1:0] alu_decode(input aluop_e aluop,
                                                   input logic [OP_W-1:0] funct);
    logic [ALUC_W-1:0] res;
    res = ALU_ADD;
    case (aluop)
      ALUOP_SUB: res = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  res = ALU_SUB;
          FN_AND:  res = ALU_AND;
          FN_OR:   res = ALU_OR;
          FN_SLT:  res = ALU_SLT;
          default: res = ALU_ADD;
        endcase
      end
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipelined_controller_hu_hazard_unit.sv
// Hazard unit: forwarding selects and the combined stall/flush request.
// Ports: D/E source indices, E/M/W destination indices with their
// regwrite/memtoreg qualifiers, branch_d; outputs stall, forward_ad/bd
// (Decode compare forwarding) and forward_ae/be (Execute ALU operands).
module hazard_unit
  import mips_pkg::*;
#(
  parameter int unsigned REGW   = 5,
  parameter int unsigned FWD_EN = 1
) (
  input  logic [REGW-1:0]  rs_d,
  input  logic [REGW-1:0]  rt_d,
  input  logic [REGW-1:0]  rs_e,
  input  logic [REGW-1:0]  rt_e,
  input  logic [REGW-1:0]  writereg_e,
  input  logic [REGW-1:0]  writereg_m,
  input  logic [REGW-1:0]  writereg_w,
  input  logic             regwrite_e,
  input  logic             memtoreg_e,
  input  logic             regwrite_m,
  input  logic             memtoreg_m,
  input  logic             regwrite_w,
  input  logic             branch_d,
  output logic             stall,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic [FWD_W-1:0] forward_ae,
  output logic [FWD_W-1:0] forward_be
);

  // Qualified index match; register 0 is hard-wired and never matches.
  function automatic logic hit(input logic [REGW-1:0] a,
                               input logic [REGW-1:0] b,
                               input logic en);
    return en && (a != '0) && (a == b);
  endfunction

  logic lwstall;
  logic branchstall;

  // Forward selects and stall; M takes priority over W.
  always_comb begin
    forward_ae  = FWD_RF;
    forward_be  = FWD_RF;
    forward_ad  = 1'b0;
    forward_bd  = 1'b0;
    lwstall     = 1'b0;
    branchstall = 1'b0;
    stall       = 1'b0;
    if (FWD_EN != 0) begin
      if (hit(rs_e, writereg_m, regwrite_m))      forward_ae = FWD_MEM;
      else if (hit(rs_e, writereg_w, regwrite_w)) forward_ae = FWD_WB;
      if (hit(rt_e, writereg_m, regwrite_m))      forward_be = FWD_MEM;
      else if (hit(rt_e, writereg_w, regwrite_w)) forward_be = FWD_WB;
      forward_ad  = hit(rs_d, writereg_m, regwrite_m);
      forward_bd  = hit(rt_d, writereg_m, regwrite_m);
      lwstall     = hit(rs_d, rt_e, memtoreg_e) | hit(rt_d, rt_e, memtoreg_e);
      branchstall = branch_d &
                    (hit(rs_d, writereg_e, regwrite_e) | hit(rt_d, writereg_e, regwrite_e) |
                     hit(rs_d, writereg_m, memtoreg_m) | hit(rt_d, writereg_m, memtoreg_m));
      stall       = lwstall | branchstall;
    end else begin
      // Without forwarding, any pending E/M write to a D source must drain.
      stall = hit(rs_d, writereg_e, regwrite_e) | hit(rt_d, writereg_e, regwrite_e) |
              hit(rs_d, writereg_m, regwrite_m) | hit(rt_d, writereg_m, regwrite_m);
    end
  end

endmodule

// File: rtl/pipelined_controller_hu.sv
// Pipelined MIPS controller with hazard unit. Decodes the D-stage
// instruction, carries control through E/M/W registers and resolves
// branches/jumps in Decode.
// Ports: clk, reset (sync active-low); opD/functD, rsD/rtD/rsE/rtE,
// writeregE/M/W, EqualD in; E/M/W control, PCSrcD/ClrD, stall/flush
// and forward selects out.
module pipelined_controller_hu
  import mips_pkg::*;
#(
  parameter int unsigned REGW   = 5,
  parameter int unsigned ALUCW  = 3,
  parameter int unsigned BNE_EN = 1,
  parameter int unsigned FWD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   opD,
  input  logic [OP_W-1:0]   functD,
  input  logic [REGW-1:0]   rsD,
  input  logic [REGW-1:0]   rtD,
  input  logic [REGW-1:0]   rsE,
  input  logic [REGW-1:0]   rtE,
  input  logic [REGW-1:0]   writeregE,
  input  logic [REGW-1:0]   writeregM,
  input  logic [REGW-1:0]   writeregW,
  input  logic              EqualD,
  output logic [ALUCW-1:0]  alucontrolE,
  output logic              alusrcE,
  output logic              regdstE,
  output logic              memwriteM,
  output logic              regwriteM,
  output logic              regwriteW,
  output logic              memtoregW,
  output logic [1:0]        PCSrcD,
  output logic              ClrD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [FWD_W-1:0]  ForwardAE,
  output logic [FWD_W-1:0]  ForwardBE
);

  ctrl_t  ctrl_d;
  ctrl_t  ctrl_e;
  aluop_e aluop_d;
  logic   legal_d;
  logic   beq_d;
  logic   bne_d;
  logic   jump_d;
  logic   taken_d;
  logic   memtoreg_m;
  logic   stall;

  // Main decoder; unrecognised opcodes leave every control bit clear.
  always_comb begin
    ctrl_d  = '0;
    aluop_d = ALUOP_ADD;
    legal_d = 1'b1;
    beq_d   = 1'b0;
    bne_d   = 1'b0;
    jump_d  = 1'b0;
    case (opD)
      OP_RTYPE: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.regdst   = 1'b1;
        aluop_d         = ALUOP_FUNCT;
      end
      OP_LW: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
        ctrl_d.memtoreg = 1'b1;
      end
      OP_SW: begin
        ctrl_d.memwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      OP_BEQ: begin
        beq_d   = 1'b1;
        aluop_d = ALUOP_SUB;
      end
      OP_BNE: begin
        if (BNE_EN != 0) begin
          bne_d   = 1'b1;
          aluop_d = ALUOP_SUB;
        end else begin
          legal_d = 1'b0;
        end
      end
      OP_ADDI: begin
        ctrl_d.regwrite = 1'b1;
        ctrl_d.alusrc   = 1'b1;
      end
      OP_J:    jump_d = 1'b1;
      default: legal_d = 1'b0;
    endcase
    ctrl_d.alucontrol = legal_d ? alu_decode(aluop_d, functD) : '0;
  end

  // Branch/jump resolution; a stall holds Decode so it must not redirect.
  assign taken_d = (beq_d & EqualD) | (bne_d & ~EqualD);
  assign PCSrcD  = stall ? 2'b00 : {jump_d, taken_d};
  assign ClrD    = ~stall & (taken_d | jump_d);

  assign StallF  = stall;
  assign StallD  = stall;
  assign FlushE  = stall;

  // E/M/W control registers; a flush inserts a bubble into E.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_e     <= '0;
      regwriteM  <= 1'b0;
      memtoreg_m <= 1'b0;
      memwriteM  <= 1'b0;
      regwriteW  <= 1'b0;
      memtoregW  <= 1'b0;
    end else begin
      ctrl_e     <= stall ? '0 : ctrl_d;
      regwriteM  <= ctrl_e.regwrite;
      memtoreg_m <= ctrl_e.memtoreg;
      memwriteM  <= ctrl_e.memwrite;
      regwriteW  <= regwriteM;
      memtoregW  <= memtoreg_m;
    end
  end

  assign alucontrolE = ALUCW'(ctrl_e.alucontrol);
  assign alusrcE     = ctrl_e.alusrc;
  assign regdstE     = ctrl_e.regdst;

  hazard_unit #(
    .REGW   (REGW),
    .FWD_EN (FWD_EN)
  ) u_hazard (
    .rs_d       (rsD),
    .rt_d       (rtD),
    .rs_e       (rsE),
    .rt_e       (rtE),
    .writereg_e (writeregE),
    .writereg_m (writeregM),
    .writereg_w (writeregW),
    .regwrite_e (ctrl_e.regwrite),
    .memtoreg_e (ctrl_e.memtoreg),
    .regwrite_m (regwriteM),
    .memtoreg_m (memtoreg_m),
    .regwrite_w (regwriteW),
    .branch_d   (beq_d | bne_d),
    .stall      (stall),
    .forward_ad (ForwardAD),
    .forward_bd (ForwardBD),
    .forward_ae (ForwardAE),
    .forward_be (ForwardBE)
  );

endmodule

// File: tb/tb_pipelined_controller_hu.sv
// Bench for pipelined_controller_hu: three configurations (default,
// no-forwarding, no-bne) share one directed instruction stream. A
// behavioural model predicts every output each cycle; literal checks pin
// the key scenarios.
module tb_pipelined_controller_hu;

  logic       clk;
  logic       rst = 1'b0;
  logic [5:0] op_d = 6'h3f, funct_d = '0;
  logic [4:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
  logic [4:0] wr_e = '0, wr_m = '0, wr_w = '0;
  logic       eq_d = 1'b0;

  logic [2:0] aluc [3];
  logic       as_e [3], rdst_e [3], mw_m [3], rw_m [3], rw_w [3], mtr_w [3];
  logic [1:0] pc [3], fae [3], fbe [3];
  logic       clr [3], sf [3], sd [3], fe [3], fad [3], fbd [3];

  int checks = 0;
  int failures = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  pipelined_controller_hu dut (
    .clk(clk), .reset(rst), .opD(op_d), .functD(funct_d), .rsD(rs_d), .rtD(rt_d),
    .rsE(rs_e), .rtE(rt_e), .writeregE(wr_e), .writeregM(wr_m), .writeregW(wr_w),
    .EqualD(eq_d), .alucontrolE(aluc[0]), .alusrcE(as_e[0]), .regdstE(rdst_e[0]),
    .memwriteM(mw_m[0]), .regwriteM(rw_m[0]), .regwriteW(rw_w[0]), .memtoregW(mtr_w[0]),
    .PCSrcD(pc[0]), .ClrD(clr[0]), .StallF(sf[0]), .StallD(sd[0]), .FlushE(fe[0]),
    .ForwardAD(fad[0]), .ForwardBD(fbd[0]), .ForwardAE(fae[0]), .ForwardBE(fbe[0]));

  pipelined_controller_hu #(.FWD_EN(0)) dut_nf (
    .clk(clk), .reset(rst), .opD(op_d), .functD(funct_d), .rsD(rs_d), .rtD(rt_d),
    .rsE(rs_e), .rtE(rt_e), .writeregE(wr_e), .writeregM(wr_m), .writeregW(wr_w),
    .EqualD(eq_d), .alucontrolE(aluc[1]), .alusrcE(as_e[1]), .regdstE(rdst_e[1]),
    .memwriteM(mw_m[1]), .regwriteM(rw_m[1]), .regwriteW(rw_w[1]), .memtoregW(mtr_w[1]),
    .PCSrcD(pc[1]), .ClrD(clr[1]), .StallF(sf[1]), .StallD(sd[1]), .FlushE(fe[1]),
    .ForwardAD(fad[1]), .ForwardBD(fbd[1]), .ForwardAE(fae[1]), .ForwardBE(fbe[1]));

  pipelined_controller_hu #(.BNE_EN(0)) dut_nb (
    .clk(clk), .reset(rst), .opD(op_d), .functD(funct_d), .rsD(rs_d), .rtD(rt_d),
    .rsE(rs_e), .rtE(rt_e), .writeregE(wr_e), .writeregM(wr_m), .writeregW(wr_w),
    .EqualD(eq_d), .alucontrolE(aluc[2]), .alusrcE(as_e[2]), .regdstE(rdst_e[2]),
    .memwriteM(mw_m[2]), .regwriteM(rw_m[2]), .regwriteW(rw_w[2]), .memtoregW(mtr_w[2]),
    .PCSrcD(pc[2]), .ClrD(clr[2]), .StallF(sf[2]), .StallD(sd[2]), .FlushE(fe[2]),
    .ForwardAD(fad[2]), .ForwardBD(fbd[2]), .ForwardAE(fae[2]), .ForwardBE(fbe[2]));

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic rw, mtr, mw, as, rdst;
    logic [2:0] ac;
    logic beq, bne, jmp;
  } mctl_t;

  bit fwd_cfg [3] = '{1'b1, 1'b0, 1'b1};
  bit bne_cfg [3] = '{1'b1, 1'b1, 1'b0};

  bit       e_rw [3], e_mtr [3], e_mw [3], e_as [3], e_rdst [3];
  bit [2:0] e_ac [3];
  bit       m_rw [3], m_mtr [3], m_mw [3], w_rw [3], w_mtr [3];

  int lead = 0;
  bit lead_flush = 1'b0;

  function automatic logic [2:0] alu_m(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'd2;
      6'h22: return 3'd6;
      6'h24: return 3'd0;
      6'h25: return 3'd1;
      6'h2a: return 3'd7;
      default: return 3'd2;
    endcase
  endfunction

  function automatic mctl_t decode_m(input logic [5:0] op, input logic [5:0] fn, input bit bne_en);
    mctl_t c;
    c = '0;
    case (op)
      6'h00: begin c.rw = 1; c.rdst = 1; c.ac = alu_m(fn); end
      6'h23: begin c.rw = 1; c.as = 1; c.mtr = 1; c.ac = 3'd2; end
      6'h2b: begin c.mw = 1; c.as = 1; c.ac = 3'd2; end
      6'h04: begin c.beq = 1; c.ac = 3'd6; end
      6'h05: if (bne_en) begin c.bne = 1; c.ac = 3'd6; end
      6'h08: begin c.rw = 1; c.as = 1; c.ac = 3'd2; end
      6'h02: begin c.jmp = 1; c.ac = 3'd2; end
      default: c = '0;
    endcase
    return c;
  endfunction

  function automatic bit hit(input logic [4:0] a, input logic [4:0] b, input bit en);
    return en && (a != 5'd0) && (a == b);
  endfunction

  logic [20:0] act [3];
  always_comb
    for (int i = 0; i < 3; i++)
      act[i] = {aluc[i], as_e[i], rdst_e[i], mw_m[i], rw_m[i], rw_w[i], mtr_w[i],
                pc[i], clr[i], sf[i], sd[i], fe[i], fad[i], fbd[i], fae[i], fbe[i]};

  // Compare every instance against the model, then advance model state.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      mctl_t    c;
      bit       st, tk, ad, bd;
      bit [1:0] ae, be, pcs;
      logic [20:0] ex;
      c  = decode_m(op_d, funct_d, bne_cfg[i]);
      ae = 0; be = 0; ad = 0; bd = 0;
      if (fwd_cfg[i]) begin
        ae = hit(rs_e, wr_m, m_rw[i]) ? 2'd2 : (hit(rs_e, wr_w, w_rw[i]) ? 2'd1 : 2'd0);
        be = hit(rt_e, wr_m, m_rw[i]) ? 2'd2 : (hit(rt_e, wr_w, w_rw[i]) ? 2'd1 : 2'd0);
        ad = hit(rs_d, wr_m, m_rw[i]);
        bd = hit(rt_d, wr_m, m_rw[i]);
        st = hit(rs_d, rt_e, e_mtr[i]) || hit(rt_d, rt_e, e_mtr[i]) ||
             ((c.beq || c.bne) &&
              (hit(rs_d, wr_e, e_rw[i]) || hit(rt_d, wr_e, e_rw[i]) ||
               hit(rs_d, wr_m, m_mtr[i]) || hit(rt_d, wr_m, m_mtr[i])));
      end else begin
        st = hit(rs_d, wr_e, e_rw[i]) || hit(rt_d, wr_e, e_rw[i]) ||
             hit(rs_d, wr_m, m_rw[i]) || hit(rt_d, wr_m, m_rw[i]);
      end
      tk  = (c.beq && eq_d) || (c.bne && !eq_d);
      pcs = st ? 2'b00 : {c.jmp, tk};
      ex  = {e_ac[i], e_as[i], e_rdst[i], m_mw[i], m_rw[i], w_rw[i], w_mtr[i],
             pcs, (!st && (tk || c.jmp)), st, st, st, ad, bd, ae, be};
      checks++;
      if (act[i] !== ex) begin
        failures++;
        $display("FAIL model_cmp inst=%0d t=%0t actual=%h required=%h", i, $time, act[i], ex);
      end
      if (i == lead) lead_flush = st;
      if (!rst) begin
        {e_rw[i], e_mtr[i], e_mw[i], e_as[i], e_rdst[i], e_ac[i]} = '0;
        {m_rw[i], m_mtr[i], m_mw[i], w_rw[i], w_mtr[i]} = '0;
      end else begin
        w_rw[i] = m_rw[i]; w_mtr[i] = m_mtr[i];
        m_rw[i] = e_rw[i]; m_mtr[i] = e_mtr[i]; m_mw[i] = e_mw[i];
        if (st) {e_rw[i], e_mtr[i], e_mw[i], e_as[i], e_rdst[i], e_ac[i]} = '0;
        else {e_rw[i], e_mtr[i], e_mw[i], e_as[i], e_rdst[i], e_ac[i]} =
               {c.rw, c.mtr, c.mw, c.as, c.rdst, c.ac};
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic eq;
  } instr_t;

  instr_t d_q = '{op: 6'h3f, default: '0};

  function automatic instr_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic eq);
    instr_t x;
    x.op = op; x.fn = fn; x.rs = rs; x.rt = rt; x.rd = rd; x.eq = eq;
    return x;
  endfunction

  function automatic instr_t rt_i(input logic [5:0] fn, input logic [4:0] rd,
                                  input logic [4:0] rs, input logic [4:0] rt);
    return mk(6'h00, fn, rs, rt, rd, 1'b0);
  endfunction

  localparam instr_t NOP = '{op: 6'h3f, default: '0};

  // One clock: advance the datapath index pipeline, present new D inputs.
  task automatic cycle(input instr_t nd, input logic r);
    @(posedge clk);
    #1;
    wr_w = wr_m;
    wr_m = wr_e;
    if (lead_flush) begin
      rs_e = '0; rt_e = '0; wr_e = '0;
    end else begin
      rs_e = d_q.rs; rt_e = d_q.rt;
      wr_e = (d_q.op == 6'h00) ? d_q.rd : d_q.rt;
    end
    d_q = nd;
    op_d = nd.op; funct_d = nd.fn; rs_d = nd.rs; rt_d = nd.rt; eq_d = nd.eq;
    rst = r;
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cycle(NOP, 1'b1);
  endtask

  logic [5:0] fn_tab [4] = '{6'h24, 6'h25, 6'h2a, 6'h3f};
  logic [2:0] ac_tab [4] = '{3'd0, 3'd1, 3'd7, 3'd2};

  initial begin
    // reset
    cycle(NOP, 1'b0);
    cycle(NOP, 1'b0);
    lit("rst_regwriteM", rw_m[0], 0);
    lit("rst_regwriteW", rw_w[0], 0);
    lit("rst_alucontrolE", aluc[0], 0);
    lit("rst_memwriteM", mw_m[0], 0);
    drain(2);

    // lw $2 ; add $3,$2,$4 -> one load-use stall then WB forward
    cycle(mk(6'h23, 0, 5'd1, 5'd2, 0, 0), 1'b1);
    cycle(rt_i(6'h20, 5'd3, 5'd2, 5'd4), 1'b1);
    lit("lw_stallF", sf[0], 1);
    lit("lw_stallD", sd[0], 1);
    lit("lw_flushE", fe[0], 1);
    lit("lw_alusrcE", as_e[0], 1);
    lit("lw_alucE", aluc[0], 3'd2);
    cycle(rt_i(6'h20, 5'd3, 5'd2, 5'd4), 1'b1);
    lit("lw_stall_gone", sf[0], 0);
    lit("lw_forwardAD", fad[0], 1);
    cycle(NOP, 1'b1);
    lit("lw_forwardAE", fae[0], 2'b01);
    drain(3);

    // add $5 ; sub $6,$5,$3 -> MEM forward, no stall
    cycle(rt_i(6'h20, 5'd5, 5'd1, 5'd2), 1'b1);
    cycle(rt_i(6'h22, 5'd6, 5'd5, 5'd3), 1'b1);
    lit("alu_nostall", sf[0], 0);
    cycle(NOP, 1'b1);
    lit("alu_forwardAE", fae[0], 2'b10);
    lit("sub_alucE", aluc[0], 3'd6);
    lit("sub_regdstE", rdst_e[0], 1);
    drain(3);

    // same pair without forwarding: two stall cycles
    lead = 1;
    cycle(rt_i(6'h20, 5'd5, 5'd1, 5'd2), 1'b1);
    cycle(rt_i(6'h22, 5'd6, 5'd5, 5'd3), 1'b1);
    lit("nf_stall1", sf[1], 1);
    cycle(rt_i(6'h22, 5'd6, 5'd5, 5'd3), 1'b1);
    lit("nf_stall2", sf[1], 1);
    lit("nf_fwdAD", fad[1], 0);
    cycle(rt_i(6'h22, 5'd6, 5'd5, 5'd3), 1'b1);
    lit("nf_stall_end", sf[1], 0);
    cycle(NOP, 1'b1);
    lit("nf_forwardAE", fae[1], 2'b00);
    lead = 0;
    drain(3);

    // beq taken, no hazard
    cycle(mk(6'h04, 0, 5'd7, 5'd8, 0, 1'b1), 1'b1);
    lit("beq_pcsrc", pc[0], 2'b01);
    lit("beq_clr", clr[0], 1);
    cycle(NOP, 1'b1);
    drain(2);

    // bne
    cycle(mk(6'h05, 0, 5'd7, 5'd8, 0, 1'b1), 1'b1);
    lit("bne_eq_pcsrc", pc[0], 2'b00);
    lit("bne_eq_clr", clr[0], 0);
    cycle(mk(6'h05, 0, 5'd7, 5'd8, 0, 1'b0), 1'b1);
    lit("bne_ne_pcsrc", pc[0], 2'b01);
    lit("nobne_pcsrc", pc[2], 2'b00);
    lit("nobne_clr", clr[2], 0);
    cycle(NOP, 1'b1);
    lit("bne_alucE", aluc[0], 3'd6);
    lit("nobne_alucE", aluc[2], 3'd0);
    drain(2);

    // beq depending on add in E -> branchstall, then ForwardAD
    cycle(rt_i(6'h20, 5'd9, 5'd1, 5'd2), 1'b1);
    cycle(mk(6'h04, 0, 5'd9, 5'd10, 0, 1'b1), 1'b1);
    lit("bstall_stallD", sd[0], 1);
    lit("bstall_pcsrc", pc[0], 2'b00);
    cycle(mk(6'h04, 0, 5'd9, 5'd10, 0, 1'b1), 1'b1);
    lit("bstall_forwardAD", fad[0], 1);
    lit("bstall_pcsrc2", pc[0], 2'b01);
    cycle(NOP, 1'b1);
    drain(2);

    // jump
    cycle(mk(6'h02, 0, 0, 0, 0, 0), 1'b1);
    lit("j_pcsrc", pc[0], 2'b10);
    lit("j_clr", clr[0], 1);
    cycle(NOP, 1'b1);

    // ALU control for remaining functs
    for (int k = 0; k < 4; k++) begin
      cycle(rt_i(fn_tab[k], 5'd0, 5'd0, 5'd0), 1'b1);
      cycle(NOP, 1'b1);
      lit("funct_alucE", aluc[0], 8'(ac_tab[k]));
    end
    drain(2);

    // mid-stream reset with sw in E
    cycle(rt_i(6'h20, 5'd11, 5'd1, 5'd2), 1'b1);
    cycle(mk(6'h2b, 0, 5'd1, 5'd2, 0, 0), 1'b1);
    cycle(NOP, 1'b0);
    lit("pre_rst_regwriteM", rw_m[0], 1);
    cycle(NOP, 1'b0);
    lit("rst_mid_memwriteM", mw_m[0], 0);
    lit("rst_mid_regwriteM", rw_m[0], 0);
    lit("rst_mid_regwriteW", rw_w[0], 0);
    cycle(NOP, 1'b0);
    lit("rst_hold_regwriteM", rw_m[0], 0);
    lit("rst_hold_regwriteW", rw_w[0], 0);
    drain(2);

    // $0 destination never forwards
    cycle(rt_i(6'h20, 5'd0, 5'd1, 5'd2), 1'b1);
    cycle(rt_i(6'h22, 5'd6, 5'd0, 5'd3), 1'b1);
    cycle(NOP, 1'b1);
    lit("r0_regwriteM", rw_m[0], 1);
    lit("r0_forwardAE", fae[0], 2'b00);
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
